// File: rtl/decode_stage.sv
// RV32 decode stage: one output register holding the control word; 1-cycle accept-to-valid latency.
// Backpressure: the word holds while out_ready=0; in_ready also drops for load-use hazards, mul/div busy and flush.
module decode_stage #(
    parameter int M_EXT  = 0,
    parameter int MD_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Type_alu,
    output logic [2:0]  Type_dm,
    output logic [2:0]  salida_funct3,
    output logic        store,
    output logic        controlALU,
    output logic        controlOp1,
    output logic [1:0]  controlRF,
    output logic        we,
    output logic [2:0]  funct_imm,
    output logic [4:0]  BrOp,
    output logic        is_md,
    output logic [2:0]  md_op,
    output logic        illegal,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] MD_INIT   = 8'(MD_LAT - 1);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    assign w_op = instr[6:0];
    assign w_f3 = instr[14:12];
    assign w_f7 = instr[31:25];

    logic       w_type_alu;
    logic [2:0] w_type_dm;
    logic [2:0] w_sal_f3;
    logic       w_store;
    logic       w_ctrl_alu;
    logic       w_ctrl_op1;
    logic [1:0] w_ctrl_rf;
    logic       w_we;
    logic [2:0] w_funct_imm;
    logic [4:0] w_brop;
    logic       w_is_md;
    logic [2:0] w_md_op;
    logic       w_illegal;
    logic       w_is_load;
    logic       w_uses_rs2;

    always_comb begin
        w_type_alu  = 1'b0;
        w_type_dm   = 3'b000;
        w_sal_f3    = 3'b000;
        w_store     = 1'b0;
        w_ctrl_alu  = 1'b0;
        w_ctrl_op1  = 1'b0;
        w_ctrl_rf   = 2'b00;
        w_we        = 1'b0;
        w_funct_imm = 3'b000;
        w_brop      = 5'b00000;
        w_is_md     = 1'b0;
        w_md_op     = 3'b000;
        w_illegal   = 1'b0;
        w_is_load   = 1'b0;

        case (w_op)
            OP_R: begin
                w_we      = 1'b1;
                w_ctrl_rf = 2'b01;
                if (w_f7 == 7'b0100000) begin
                    // only sub and sra exist with the alternate funct7
                    if (w_f3 == 3'b000) begin
                        w_type_alu = 1'b1;
                        w_sal_f3   = 3'b000;
                    end else if (w_f3 == 3'b101) begin
                        w_type_alu = 1'b1;
                        w_sal_f3   = 3'b001;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (w_f7 == 7'b0000000) begin
                    if (w_f3 == 3'b011) begin
                        w_type_alu = 1'b1;
                        w_sal_f3   = 3'b010;
                    end else begin
                        w_sal_f3 = w_f3;
                    end
                end else if (w_f7 == 7'b0000001 && M_EXT != 0) begin
                    w_is_md = 1'b1;
                    w_md_op = w_f3;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_IALU: begin
                w_ctrl_alu = 1'b1;
                w_we       = 1'b1;
                w_ctrl_rf  = 2'b01;
                if (w_f3 == 3'b011) begin
                    w_type_alu = 1'b1;
                    w_sal_f3   = 3'b010;
                end else if (w_f3 == 3'b101 && instr[30]) begin
                    w_type_alu = 1'b1;
                    w_sal_f3   = 3'b001;
                end else begin
                    w_sal_f3 = w_f3;
                end
            end
            OP_LOAD: begin
                w_we       = 1'b1;
                w_ctrl_alu = 1'b1;
                w_is_load  = 1'b1;
                case (w_f3)
                    3'b000:  w_type_dm = 3'b000;
                    3'b001:  w_type_dm = 3'b001;
                    3'b010:  w_type_dm = 3'b010;
                    3'b100:  w_type_dm = 3'b011;
                    3'b101:  w_type_dm = 3'b100;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_store     = 1'b1;
                w_ctrl_alu  = 1'b1;
                w_funct_imm = 3'b001;
                w_type_dm   = w_f3;
                if (w_f3 > 3'b010) begin
                    w_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                w_ctrl_alu  = 1'b1;
                w_ctrl_op1  = 1'b1;
                w_funct_imm = 3'b010;
                w_brop      = {2'b01, w_f3};
                if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
                    w_illegal = 1'b1;
                end
            end
            OP_LUI, OP_AUIPC: begin
                w_we        = 1'b1;
                w_ctrl_rf   = 2'b10;
                w_funct_imm = 3'b011;
                w_ctrl_op1  = (w_op == OP_AUIPC);
            end
            OP_JAL, OP_JALR: begin
                w_we        = 1'b1;
                w_ctrl_rf   = 2'b11;
                w_ctrl_alu  = 1'b1;
                w_brop      = 5'b11111;
                w_ctrl_op1  = (w_op == OP_JAL);
                w_funct_imm = (w_op == OP_JAL) ? 3'b100 : 3'b000;
            end
            OP_SYSTEM: begin
            end
            default: w_illegal = 1'b1;
        endcase

        // an illegal word carries nothing but the flag, so it can never write or branch
        if (w_illegal) begin
            w_type_alu  = 1'b0;
            w_type_dm   = 3'b000;
            w_sal_f3    = 3'b000;
            w_store     = 1'b0;
            w_ctrl_alu  = 1'b0;
            w_ctrl_op1  = 1'b0;
            w_ctrl_rf   = 2'b00;
            w_we        = 1'b0;
            w_funct_imm = 3'b000;
            w_brop      = 5'b00000;
            w_is_md     = 1'b0;
            w_md_op     = 3'b000;
            w_is_load   = 1'b0;
        end
    end

    assign w_uses_rs2 = (w_op == OP_R) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

    logic       r_out_valid;
    logic       r_is_load;
    logic [7:0] r_cnt;
    logic       r_type_alu;
    logic [2:0] r_type_dm;
    logic [2:0] r_sal_f3;
    logic       r_store;
    logic       r_ctrl_alu;
    logic       r_ctrl_op1;
    logic [1:0] r_ctrl_rf;
    logic       r_we;
    logic [2:0] r_funct_imm;
    logic [4:0] r_brop;
    logic       r_is_md;
    logic [2:0] r_md_op;
    logic       r_illegal;
    logic [4:0] r_rd;
    logic [4:0] r_rs1;
    logic [4:0] r_rs2;

    logic w_hazard;
    logic w_accept;

    assign w_hazard = r_out_valid && r_is_load && (r_rd != 5'd0) &&
                      ((r_rd == instr[19:15]) || (w_uses_rs2 && (r_rd == instr[24:20])));
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && (r_cnt == 8'd0) && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_is_load   <= 1'b0;
            r_cnt       <= 8'd0;
            r_type_alu  <= 1'b0;
            r_type_dm   <= 3'b000;
            r_sal_f3    <= 3'b000;
            r_store     <= 1'b0;
            r_ctrl_alu  <= 1'b0;
            r_ctrl_op1  <= 1'b0;
            r_ctrl_rf   <= 2'b00;
            r_we        <= 1'b0;
            r_funct_imm <= 3'b000;
            r_brop      <= 5'b00000;
            r_is_md     <= 1'b0;
            r_md_op     <= 3'b000;
            r_illegal   <= 1'b0;
            r_rd        <= 5'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_cnt       <= 8'd0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_is_load   <= w_is_load;
                r_type_alu  <= w_type_alu;
                r_type_dm   <= w_type_dm;
                r_sal_f3    <= w_sal_f3;
                r_store     <= w_store;
                r_ctrl_alu  <= w_ctrl_alu;
                r_ctrl_op1  <= w_ctrl_op1;
                r_ctrl_rf   <= w_ctrl_rf;
                r_we        <= w_we;
                r_funct_imm <= w_funct_imm;
                r_brop      <= w_brop;
                r_is_md     <= w_is_md;
                r_md_op     <= w_md_op;
                r_illegal   <= w_illegal;
                r_rd        <= instr[11:7];
                r_rs1       <= instr[19:15];
                r_rs2       <= instr[24:20];
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && w_is_md) begin
                r_cnt <= MD_INIT;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign Type_alu      = r_type_alu;
    assign Type_dm       = r_type_dm;
    assign salida_funct3 = r_sal_f3;
    assign store         = r_store;
    assign controlALU    = r_ctrl_alu;
    assign controlOp1    = r_ctrl_op1;
    assign controlRF     = r_ctrl_rf;
    assign we            = r_we;
    assign funct_imm     = r_funct_imm;
    assign BrOp          = r_brop;
    assign is_md         = r_is_md;
    assign md_op         = r_md_op;
    assign illegal       = r_illegal;
    assign rd            = r_rd;
    assign rs1           = r_rs1;
    assign rs2           = r_rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: M_EXT=1/MD_LAT=4 main instance plus an M_EXT=0 instance for the mul-illegal case.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_valid0;
    logic        out_ready;
    logic [31:0] instr;

    logic        in_ready, out_valid, Type_alu, store, controlALU, controlOp1, we, is_md, illegal;
    logic [2:0]  Type_dm, salida_funct3, funct_imm, md_op;
    logic [1:0]  controlRF;
    logic [4:0]  BrOp, rd, rs1, rs2;

    logic        in_ready0, out_valid0, Type_alu0, store0, controlALU0, controlOp10, we0, is_md0, illegal0;
    logic [2:0]  Type_dm0, salida_funct30, funct_imm0, md_op0;
    logic [1:0]  controlRF0;
    logic [4:0]  BrOp0, rd0, rs10, rs20;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.M_EXT(1), .MD_LAT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .Type_alu(Type_alu), .Type_dm(Type_dm), .salida_funct3(salida_funct3), .store(store),
        .controlALU(controlALU), .controlOp1(controlOp1), .controlRF(controlRF), .we(we),
        .funct_imm(funct_imm), .BrOp(BrOp), .is_md(is_md), .md_op(md_op), .illegal(illegal),
        .rd(rd), .rs1(rs1), .rs2(rs2)
    );

    decode_stage #(.M_EXT(0), .MD_LAT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .instr(instr), .out_valid(out_valid0), .out_ready(out_ready),
        .Type_alu(Type_alu0), .Type_dm(Type_dm0), .salida_funct3(salida_funct30), .store(store0),
        .controlALU(controlALU0), .controlOp1(controlOp10), .controlRF(controlRF0), .we(we0),
        .funct_imm(funct_imm0), .BrOp(BrOp0), .is_md(is_md0), .md_op(md_op0), .illegal(illegal0),
        .rd(rd0), .rs1(rs10), .rs2(rs20)
    );

    localparam logic [31:0] ADD   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] SUB   = {7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33};
    localparam logic [31:0] SRA   = {7'h20, 5'd2, 5'd1, 3'd5, 5'd5, 7'h33};
    localparam logic [31:0] SRAI  = {7'h20, 5'd3, 5'd1, 3'd5, 5'd6, 7'h13};
    localparam logic [31:0] SLTIU = {12'd5, 5'd1, 3'd3, 5'd7, 7'h13};
    localparam logic [31:0] LW5   = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
    localparam logic [31:0] ADD6  = {7'h00, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] LW0   = {12'd0, 5'd1, 3'd2, 5'd0, 7'h03};
    localparam logic [31:0] ADD6Z = {7'h00, 5'd1, 5'd0, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] BEQ   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63};
    localparam logic [31:0] ADD8  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] MULHU = {7'h01, 5'd2, 5'd1, 3'd3, 5'd9, 7'h33};
    localparam logic [31:0] ADD10 = {7'h00, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33};
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] LWBAD = {12'd0, 5'd1, 3'd7, 5'd5, 7'h03};
    localparam logic [31:0] SW    = {7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'h23};
    localparam logic [31:0] AUIPC = {20'h00001, 5'd11, 7'h17};
    localparam logic [31:0] JAL   = {20'h00000, 5'd1, 7'h6F};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    logic [41:0] all_outs;
    assign all_outs = {out_valid, Type_alu, Type_dm, salida_funct3, store, controlALU, controlOp1,
                       controlRF, we, funct_imm, BrOp, is_md, md_op, illegal, rd, rs1, rs2};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1; instr = '0;
        repeat (2) next_cycle();
        check("reset_outs", 64'(all_outs), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // back-to-back ALU stream: view = {out_valid, Type_alu, salida_funct3, controlALU, we, controlRF}
        rst_n = 1'b1; in_valid = 1'b1; instr = ADD;
        next_cycle();
        check("add", 64'({out_valid, Type_alu, salida_funct3, controlALU, we, controlRF}), 64'(9'b1_0_000_0_1_01));
        instr = SUB;
        next_cycle();
        check("sub", 64'({out_valid, Type_alu, salida_funct3, controlALU, we, controlRF}), 64'(9'b1_1_000_0_1_01));
        instr = SRA;
        next_cycle();
        check("sra", 64'({out_valid, Type_alu, salida_funct3, controlALU, we, controlRF}), 64'(9'b1_1_001_0_1_01));
        instr = SRAI;
        next_cycle();
        check("srai", 64'({out_valid, Type_alu, salida_funct3, controlALU, we, controlRF, funct_imm}), 64'(12'b1_1_001_1_1_01_000));
        instr = SLTIU;
        next_cycle();
        check("sltiu", 64'({out_valid, Type_alu, salida_funct3, controlALU, we, controlRF}), 64'(9'b1_1_010_1_1_01));

        // load-use: exactly one bubble
        instr = LW5;
        next_cycle();
        check("lw", 64'({out_valid, we, controlRF, controlALU, Type_dm, store, rd}), 64'({1'b1, 1'b1, 2'b00, 1'b1, 3'b010, 1'b0, 5'd5}));
        instr = ADD6;
        #1;
        check("hazard_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        check("bubble", 64'({out_valid, in_ready}), 64'(2'b01));
        next_cycle();
        check("after_bubble", 64'({out_valid, rd}), 64'({1'b1, 5'd6}));
        instr = LW0;
        next_cycle();
        check("lw_x0", 64'({out_valid, rd}), 64'({1'b1, 5'd0}));
        instr = ADD6Z;
        #1;
        check("x0_no_hazard", 64'(in_ready), 64'd1);
        next_cycle();
        check("x0_follow", 64'({out_valid, rd}), 64'({1'b1, 5'd6}));

        // beq held under backpressure for three cycles
        instr = BEQ;
        next_cycle();
        out_ready = 1'b0; instr = ADD8;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("beq_hold", 64'({out_valid, BrOp, controlALU, controlOp1, funct_imm, rs1, rs2, in_ready}),
                  64'({1'b1, 5'b01000, 1'b1, 1'b1, 3'b010, 5'd1, 5'd2, 1'b0}));
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        check("after_hold", 64'({out_valid, rd}), 64'({1'b1, 5'd8}));

        // mul/div occupancy, and the same encoding without M_EXT
        instr = MULHU; in_valid0 = 1'b1;
        next_cycle();
        in_valid0 = 1'b0;
        check("mulhu", 64'({out_valid, is_md, md_op, we, controlRF, illegal, rd}), 64'({1'b1, 1'b1, 3'b011, 1'b1, 2'b01, 1'b0, 5'd9}));
        check("mul_no_mext", 64'({out_valid0, illegal0, we0, is_md0}), 64'(4'b1100));
        instr = ADD10;
        for (int i = 0; i < 3; i++) begin
            check("md_busy", 64'(in_ready), 64'd0);
            next_cycle();
        end
        check("md_done", 64'(in_ready), 64'd1);
        next_cycle();
        check("after_md", 64'({out_valid, is_md, rd}), 64'({1'b1, 1'b0, 5'd10}));

        // illegal encodings, then legal store / auipc / jal
        instr = ILL;
        next_cycle();
        check("ill_opcode", 64'({out_valid, illegal, we, store, BrOp}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 5'd0}));
        instr = LWBAD;
        next_cycle();
        check("ill_lw_f3", 64'({out_valid, illegal, we, store, Type_dm}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 3'd0}));
        instr = SW;
        next_cycle();
        check("sw", 64'({out_valid, store, controlALU, funct_imm, Type_dm, we, illegal}), 64'({1'b1, 1'b1, 1'b1, 3'b001, 3'b010, 1'b0, 1'b0}));
        instr = AUIPC;
        next_cycle();
        check("auipc", 64'({out_valid, we, controlRF, funct_imm, controlOp1, controlALU, rd}), 64'({1'b1, 1'b1, 2'b10, 3'b011, 1'b1, 1'b0, 5'd11}));
        instr = JAL;
        next_cycle();
        check("jal", 64'({out_valid, we, controlRF, controlALU, controlOp1, funct_imm, BrOp, rd}),
              64'({1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 3'b100, 5'b11111, 5'd1}));

        // flush kills a held word
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b0;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        flush = 1'b0; out_ready = 1'b1;
        #1;
        check("flush_out_valid", 64'({out_valid, in_ready}), 64'(2'b01));

        // flush clears the busy counter at cnt=2
        instr = MULHU; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        check("md_cnt3", 64'(in_ready), 64'd0);
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        #1;
        check("flush_cnt", 64'({out_valid, in_ready}), 64'(2'b01));

        // asynchronous reset mid-operation
        instr = MULHU; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        check("pre_reset", 64'({out_valid, in_ready}), 64'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        check("arst_outs", 64'(all_outs), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; instr = ADD;
        next_cycle();
        check("post_reset", 64'({out_valid, rd}), 64'({1'b1, 5'd3}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational control unit, forming the decode stage of the RV32 pipeline. It accepts a fetched instruction over a valid/ready handshake and decodes it into the team's existing control-word encoding. It holds the result in a single output register. It also inserts load-use bubbles, flags illegal encodings, honours a flush, and optionally decodes RV32M with a busy counter modelling the iterative mul/div unit.

## Interface
Parameters:
- M_EXT, 0: 1 enables RV32M decode (opcode 0110011, funct7 0000001); 0 makes those encodings illegal.
- MD_LAT, 32: mul/div occupancy in cycles, legal range 1..255.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of the held instruction and busy counter
- in_valid  in  1  instr valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- out_valid  out  1  control word valid
- out_ready  in  1  execute stage accepts control word
- Type_alu  out  1; Type_dm  out  3; salida_funct3  out  3; store  out  1; controlALU  out  1; controlOp1  out  1; controlRF  out  2; we  out  1; funct_imm  out  3; BrOp  out  5: existing control-word encoding
- is_md  out  1  mul/div instruction; md_op  out  3  its funct3
- illegal  out  1  undecodable instruction (held word is a NOP otherwise)
- rd, rs1, rs2  out  5 each  register fields

## Operation
- Every output register resets to 0; out_valid=0, busy counter=0.
- Accept occurs when in_valid && in_ready. in_ready = (!out_valid || out_ready) && !hazard && (cnt==0) && !flush.
- On accept, the register loads the decoded word. Otherwise, when out_valid && out_ready, out_valid clears (bubble).
- Decode is fully specified: every field has a default of 0. No field holds stale values across instructions.
- R (0110011): controlRF=01, we=1. Type_alu=1 only for sub, sltu, sra. salida_funct3=funct3, except sltu→010 and sra→001. funct7 other than 0000000/0100000 (or 0000001 with M_EXT) is illegal; so is 0100000 with funct3 other than 000/101.
- I-ALU (0010011): controlALU=1, we=1, controlRF=01, funct_imm=000. Same funct3 map as R. srai gives salida_funct3=001 and Type_alu=1, matching sra.
- Load (0000011): we=1, controlRF=00, controlALU=1. Type_dm is lb 000, lh 001, lw 010, lbu 011, lhu 100. funct3 011/110/111 is illegal.
- Store (0100011): store=1, controlALU=1, funct_imm=001, Type_dm=funct3. funct3 >010 is illegal.
- Branch (1100011): controlALU=1, controlOp1=1, funct_imm=010, BrOp={2'b01,funct3}. funct3 010/011 is illegal.
- lui (0110111) and auipc (0010111): we=1, controlRF=10, funct_imm=011. auipc also sets controlOp1=1.
- jal (1101111): we=1, controlRF=11, controlALU=1, controlOp1=1, funct_imm=100, BrOp=11111.
- jalr (1100111): same as jal but controlOp1=0 and funct_imm=000.
- System (1110011): NOP word, no illegal flag. Any other opcode sets illegal=1 with we=0, store=0, BrOp=0.
- M_EXT: is_md=1, we=1, controlRF=01, md_op=funct3. On accept, cnt loads MD_LAT-1 and decrements to 0 each cycle.
- Hazard: out_valid && held word is a load && rd!=0 && rd matches the incoming rs1, or rs2 for R/store/branch. One bubble follows the load's departure.
- flush: out_valid←0 and cnt←0 next edge. Takes priority over accept and over the hold.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Full throughput is 1 instruction per cycle when out_ready=1 and no hazard or MD occurs.
- Output is stable while out_valid && !out_ready. in_ready is combinational from out_ready, hazard, cnt and flush only.
- Mid-operation reset clears out_valid and cnt immediately (asynchronous). The first accept can occur on the first edge after deassertion.
- MD_LAT=1 causes no extra stall.

## Test plan
- Stream add, sub, sra, srai, sltiu with out_ready=1 → consecutive out_valid; sub gives Type_alu=1/salida_funct3=000; srai gives salida_funct3=001/Type_alu=1.
- lw x5 followed by add x6,x5,x1 → exactly one bubble cycle, in_ready=0 for 1 cycle; with rd=x0 → no bubble.
- out_ready=0 for 3 cycles with beq held → fields constant with BrOp=01000, in_ready=0, no instruction lost.
- M_EXT=1, MD_LAT=4, mul followed by add → is_md=1, in_ready low for 3 cycles; M_EXT=0 → mul flagged illegal.
- Opcode 1111111 and lw with funct3=111 → illegal=1, we=0, store=0.
- flush asserted while holding jal with cnt=2 → out_valid=0 and in_ready=1 the next cycle; rst_n pulse mid-stream → all outputs 0 asynchronously.
